// File: rtl/multi_clock_divider_pkg.sv
// Shared constants for the multi-channel clock divider.
// Channel state encoding and the board and simulation defaults.
package multi_clock_divider_pkg;

  localparam int DIV_MIN = 2;

  localparam int BOARD_DIV  = 10000000;
  localparam int BOARD_HIGH = 5000000;
  localparam int SIM_DIV    = 10;
  localparam int SIM_HIGH   = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

endpackage

// File: rtl/multi_clock_divider_channel.sv
// One divider channel: period counter, active/shadow settings,
// and the IDLE/RUN state machine.
module multi_clock_divider_channel
  import multi_clock_divider_pkg::*;
#(
  parameter int CNT_W        = 24,
  parameter int DEFAULT_DIV  = BOARD_DIV,
  parameter int DEFAULT_HIGH = BOARD_HIGH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_high,
  output logic             out_clock,
  output logic             tick,
  output logic             pending
);

  localparam logic [CNT_W-1:0] RST_D = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] RST_H = CNT_W'(DEFAULT_HIGH);
  localparam logic [CNT_W-1:0] D_MIN = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  ch_state_t        state, state_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic [CNT_W-1:0] act_d, act_h;
  logic [CNT_W-1:0] sh_d, sh_h;
  logic [CNT_W-1:0] eff_d, eff_h;
  logic [CNT_W-1:0] count_inc;
  logic             out_nx, tick_nx, pending_nx;
  logic             last, apply, eff_ok;

  assign count_inc = count + ONE;
  assign last      = (state == RUN) && (count == act_d - ONE);
  assign apply     = pending && ((state == IDLE) || last);
  // The boundary edge already computes count 0 from the new settings.
  assign eff_d     = apply ? sh_d : act_d;
  assign eff_h     = apply ? sh_h : act_h;
  assign eff_ok    = (eff_d >= D_MIN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    count_nx   = count;
    out_nx     = 1'b0;
    tick_nx    = 1'b0;
    pending_nx = pending;
    if (apply) pending_nx = 1'b0;
    if (wr)    pending_nx = 1'b1;
    unique case (state)
      IDLE: begin
        count_nx = '0;
        if (enable && eff_ok) begin
          state_nx = RUN;
          out_nx   = (eff_h != '0);
          tick_nx  = 1'b1;
        end
      end
      RUN: begin
        unique case (1'b1)
          !enable: begin
            state_nx = IDLE;
            count_nx = '0;
          end
          enable && last && !eff_ok: begin
            state_nx = IDLE;
            count_nx = '0;
          end
          enable && last && eff_ok: begin
            count_nx = '0;
            out_nx   = (eff_h != '0);
            tick_nx  = 1'b1;
          end
          enable && !last: begin
            count_nx = count_inc;
            out_nx   = (count_inc < eff_h);
          end
          default: ;
        endcase
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      out_clock <= 1'b0;
      tick      <= 1'b0;
      pending   <= 1'b0;
      act_d     <= RST_D;
      act_h     <= RST_H;
      sh_d      <= RST_D;
      sh_h      <= RST_H;
    end else begin
      count     <= count_nx;
      out_clock <= out_nx;
      tick      <= tick_nx;
      pending   <= pending_nx;
      if (apply) begin
        act_d <= sh_d;
        act_h <= sh_h;
      end
      if (wr) begin
        sh_d <= wr_div;
        sh_h <= wr_high;
      end
    end
  end

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent glitch-free clock dividers with a shared
// write port for period and high-time settings.
module multi_clock_divider
  import multi_clock_divider_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 24,
  parameter int CH_W         = 2,
  parameter int DEFAULT_DIV  = BOARD_DIV,
  parameter int DEFAULT_HIGH = BOARD_HIGH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] enable,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  input  logic [CNT_W-1:0]  wr_high,
  output logic [NUM_CH-1:0] out_clock,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  logic [NUM_CH-1:0] wr_hit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Unused codes of wr_ch match no channel and are dropped.
    assign wr_hit[i] = wr_en && (wr_ch == CH_W'(i));

    multi_clock_divider_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .DEFAULT_HIGH(DEFAULT_HIGH)
    ) u_ch (
      .clock    (clock),
      .reset_n  (reset_n),
      .enable   (enable[i]),
      .wr       (wr_hit[i]),
      .wr_div   (wr_div),
      .wr_high  (wr_high),
      .out_clock(out_clock[i]),
      .tick     (tick[i]),
      .pending  (pending[i])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Bench for multi_clock_divider: table vectors, directed corner
// sequences, and random traffic against a cycle reference model.
module tb_multi_clock_divider;
  import multi_clock_divider_pkg::*;

  localparam int NCH = 3;
  localparam int CW  = 8;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [NCH-1:0] enable = '0;
  logic           wr_en = 1'b0;
  logic [1:0]     wr_ch = '0;
  logic [CW-1:0]  wr_div = '0;
  logic [CW-1:0]  wr_high = '0;
  logic [NCH-1:0] out_clock, tick, pending;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  multi_clock_divider #(
    .NUM_CH(NCH), .CNT_W(CW), .CH_W(2),
    .DEFAULT_DIV(SIM_DIV), .DEFAULT_HIGH(SIM_HIGH)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
    .wr_high(wr_high), .out_clock(out_clock),
    .tick(tick), .pending(pending)
  );

  always #5 clock = ~clock;

  // Reference model: phase within the period plus settings.
  bit             m_run [NCH];
  int             m_pos [NCH];
  int             m_d   [NCH];
  int             m_h   [NCH];
  int             m_sd  [NCH];
  int             m_sh  [NCH];
  logic [NCH-1:0] m_out, m_tick, m_pend;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_run[c] <= 1'b0; m_pos[c] <= 0;
        m_d[c] <= SIM_DIV;  m_h[c] <= SIM_HIGH;
        m_sd[c] <= SIM_DIV; m_sh[c] <= SIM_HIGH;
      end
      m_out <= '0; m_tick <= '0; m_pend <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        automatic bit boundary = m_run[c] && (m_pos[c] == m_d[c] - 1);
        automatic bit ap = m_pend[c] && (!m_run[c] || boundary);
        automatic int nd = ap ? m_sd[c] : m_d[c];
        automatic int nh = ap ? m_sh[c] : m_h[c];
        automatic bit run = m_run[c];
        automatic int pos = m_pos[c];
        automatic bit o = 1'b0;
        automatic bit t = 1'b0;
        automatic bit p = m_pend[c];
        if (!enable[c]) begin
          run = 0; pos = 0;
        end else if (!m_run[c] || boundary) begin
          pos = 0;
          run = (nd >= DIV_MIN);
          o = run && (nh > 0);
          t = run;
        end else begin
          pos = pos + 1;
          o = pos < nh;
        end
        if (ap) p = 1'b0;
        if (wr_en && (int'(wr_ch) == c)) begin
          m_sd[c] <= int'(wr_div);
          m_sh[c] <= int'(wr_high);
          p = 1'b1;
        end
        m_run[c] <= run; m_pos[c] <= pos;
        m_d[c] <= nd; m_h[c] <= nh;
        m_out[c] <= o; m_tick[c] <= t; m_pend[c] <= p;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_on && reset_n) begin
      checks++;
      if ({out_clock, tick, pending} !== {m_out, m_tick, m_pend}) begin
        errors++;
        $display("FAIL model t=%0t out=%b/%b tick=%b/%b pend=%b/%b",
                 $time, out_clock, m_out, tick, m_tick,
                 pending, m_pend);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wr(input int ch, input int d, input int h);
    wr_en = 1'b1; wr_ch = 2'(ch);
    wr_div = CW'(d); wr_high = CW'(h);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input int max, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      if (tick[ch]) seen = 1'b1;
      else cyc();
    end
    check({name, "_tick_timeout"}, int'(seen), 1);
  endtask

  task automatic measure(input int ch, input int win,
                         output int highs, output int ticks);
    highs = 0; ticks = 0;
    for (int i = 0; i < win; i++) begin
      highs += int'(out_clock[ch]);
      ticks += int'(tick[ch]);
      cyc();
    end
  endtask

  typedef struct {
    int d; int h; int win; int exp_high; int exp_ticks;
  } vec_t;

  vec_t vecs [9];
  int hi, tk;

  initial begin
    vecs[0] = '{10, 5, 20, 10, 2};
    vecs[1] = '{ 8, 2, 16,  4, 2};
    vecs[2] = '{ 4, 1,  8,  2, 2};
    vecs[3] = '{ 3, 3,  6,  6, 2};
    vecs[4] = '{ 5, 0, 10,  0, 2};
    vecs[5] = '{ 4, 7,  8,  8, 2};
    vecs[6] = '{ 2, 1,  4,  2, 2};
    vecs[7] = '{ 1, 1, 20,  0, 0};
    vecs[8] = '{ 0, 0, 20,  0, 0};

    cyc(3);
    check("reset_out", int'(out_clock), 0);
    check("reset_tick", int'(tick), 0);
    check("reset_pend", int'(pending), 0);
    reset_n = 1'b1;
    chk_on = 1'b1;
    cyc();

    // Defaults: tick the cycle after enable, 5 high / 5 low.
    enable[0] = 1'b1;
    cyc();
    check("t1_first_tick", int'(tick[0]), 1);
    measure(0, 20, hi, tk);
    check("t1_highs", hi, 10);
    check("t1_ticks", tk, 2);

    // Drop enable at count 4, re-raise 3 cycles later.
    wait_tick(0, 12, "t5");
    cyc(4);
    enable[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t5_low_while_off", int'(out_clock[0]), 0);
    end
    enable[0] = 1'b1;
    cyc();
    check("t5_restart_tick", int'(tick[0]), 1);
    measure(0, 10, hi, tk);
    check("t5_restart_highs", hi, 5);
    check("t5_restart_ticks", tk, 1);

    foreach (vecs[k]) begin
      enable[0] = 1'b0;
      cyc();
      wr(0, vecs[k].d, vecs[k].h);
      enable[0] = 1'b1;
      cyc();
      if (vecs[k].exp_ticks > 0) wait_tick(0, 4, "vec");
      measure(0, vecs[k].win, hi, tk);
      check($sformatf("vec%0d_highs", k), hi, vecs[k].exp_high);
      check($sformatf("vec%0d_ticks", k), tk, vecs[k].exp_ticks);
      check($sformatf("vec%0d_pend", k), int'(pending[0]), 0);
    end

    // Reprogram a running channel at count 3.
    wr(1, 8, 2);
    enable[1] = 1'b1;
    wait_tick(1, 4, "t2a");
    cyc(3);
    wr(1, 4, 1);
    check("t2_pending", int'(pending[1]), 1);
    wait_tick(1, 8, "t2b");
    check("t2_pend_clear", int'(pending[1]), 0);
    measure(1, 8, hi, tk);
    check("t2_highs", hi, 2);
    check("t2_ticks", tk, 2);

    // Two writes before the wrap: the last one wins.
    enable[2] = 1'b1;
    wait_tick(2, 4, "t3a");
    cyc();
    wr(2, 6, 3);
    wr(2, 12, 4);
    check("t3_pending", int'(pending[2]), 1);
    wait_tick(2, 12, "t3b");
    check("t3_pend_clear", int'(pending[2]), 0);
    measure(2, 12, hi, tk);
    check("t3_highs", hi, 4);
    check("t3_ticks", tk, 1);

    // Invalid divisor keeps the channel idle until fixed.
    enable[2] = 1'b0;
    cyc();
    wr(2, 1, 0);
    enable[2] = 1'b1;
    cyc();
    measure(2, 20, hi, tk);
    check("t4_idle_highs", hi, 0);
    check("t4_idle_ticks", tk, 0);
    wr(2, 3, 3);
    wait_tick(2, 3, "t4");
    measure(2, 6, hi, tk);
    check("t4_const_high", hi, 6);
    check("t4_ticks", tk, 2);

    // Asynchronous reset mid-run with a write pending.
    enable = '1;
    wr(0, 6, 2);
    #2 reset_n = 1'b0;
    #1;
    check("t6_out", int'(out_clock), 0);
    check("t6_tick", int'(tick), 0);
    check("t6_pend", int'(pending), 0);
    enable = '0;
    cyc(2);
    reset_n = 1'b1;
    cyc();
    enable[0] = 1'b1;
    cyc();
    check("t6_tick_after", int'(tick[0]), 1);
    measure(0, 10, hi, tk);
    check("t6_default_highs", hi, 5);
    check("t6_default_ticks", tk, 1);
    wr(3, 4, 2);
    cyc();
    check("t6_bad_ch_pend", int'(pending), 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) enable = NCH'($urandom);
      wr_en = ($urandom_range(0, 9) == 0);
      wr_ch = 2'($urandom_range(0, 3));
      wr_div = CW'($urandom_range(0, 12));
      wr_high = CW'($urandom_range(0, 14));
      cyc();
    end
    wr_en = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
